// File: rtl/regfile_writeback.sv
// Write-back arbiter for the integer register file (ALU > LSU/DIV round-robin) plus pending-write scoreboard.
// Latency: an accepted result appears on rd0_o one cycle after its handshake; issue sets pending one cycle later.
// Backpressure: the ALU is never stalled; LSU/DIV readies drop whenever the ALU or the other unit owns the port.
module regfile_writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_value_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_value_i,
    output logic        lsu_ready_o,
    input  logic        div_valid_i,
    input  logic [4:0]  div_rd_i,
    input  logic [31:0] div_value_i,
    output logic        div_ready_o,
    output logic [4:0]  rd0_o,
    output logic [31:0] rd0_value_o,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    output logic        ra_pending_o,
    output logic        rb_pending_o,
    output logic [31:0] pending_o
);

    // 1 when the divider won the most recent LSU/DIV grant; reset value makes the LSU win first.
    logic        last_div_q, last_div_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] value_q, value_d;
    logic [31:0] pending_q, pending_d;
    logic        lsu_fire, div_fire;

    always_comb begin
        lsu_ready_o = !alu_valid_i && lsu_valid_i && (!div_valid_i || last_div_q);
        div_ready_o = !alu_valid_i && div_valid_i && (!lsu_valid_i || !last_div_q);
    end

    assign lsu_fire = lsu_valid_i && lsu_ready_o;
    assign div_fire = div_valid_i && div_ready_o;

    always_comb begin
        rd_d       = 5'd0;
        value_d    = 32'd0;
        last_div_d = last_div_q;
        if (alu_valid_i) begin
            rd_d    = alu_rd_i;
            value_d = alu_value_i;
        end else if (lsu_fire) begin
            rd_d       = lsu_rd_i;
            value_d    = lsu_value_i;
            last_div_d = 1'b0;
        end else if (div_fire) begin
            rd_d       = div_rd_i;
            value_d    = div_value_i;
            last_div_d = 1'b1;
        end
        // x0 results complete their handshake but never reach the register file.
        if (rd_d == 5'd0) begin
            value_d = 32'd0;
        end
    end

    // Clear for the write being committed this edge, then set for a new issue so reissue wins.
    always_comb begin
        pending_d = pending_q;
        if (rd_q != 5'd0) begin
            pending_d[rd_q] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_div_q <= 1'b1;
            rd_q       <= 5'd0;
            value_q    <= 32'd0;
            pending_q  <= 32'd0;
        end else begin
            last_div_q <= last_div_d;
            rd_q       <= rd_d;
            value_q    <= value_d;
            pending_q  <= pending_d;
        end
    end

    assign rd0_o        = rd_q;
    assign rd0_value_o  = value_q;
    assign pending_o    = pending_q;
    assign ra_pending_o = (ra_i != 5'd0) && pending_q[ra_i];
    assign rb_pending_o = (rb_i != 5'd0) && pending_q[rb_i];

endmodule
